register_file: RTL

- 32-entry x N-bit register file; the write-side counterpart of the mux32 read path.
- A 5-to-32 one-hot write decoder steers `wr_data` into exactly one register per clock.
- Two independent read ports each select one register through a 32:1 mux.
- Sits between decode and execute in the single-cycle core; x0 is hardwired to zero.

---
 rtl/rf_pkg.sv | 11 +
 rtl/decoder5to32.sv | 18 +
 rtl/mux32.sv | 17 +
 rtl/register_file.sv | 71 +++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the 32-entry register file.
package rf_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : rf_pkg

// File: rtl/decoder5to32.sv
// 5-to-32 one-hot decoder; the write-side inverse of mux32.
module decoder5to32
    import rf_pkg::*;
(
    input  logic                 ena,
    input  reg_addr_t            addr,
    output logic [REG_COUNT-1:0] onehot
);

    // At most one bit is set, and only while enabled.
    always_comb begin
        onehot = '0;
        if (ena) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule : decoder5to32

// File: rtl/mux32.sv
// 32:1 read mux selecting one N-bit word from a packed register array.
module mux32
    import rf_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [REG_COUNT-1:0][N-1:0] data_in,
    input  reg_addr_t                   sel,
    output logic [N-1:0]                data_out
);

    // Pure combinational select; no read latency.
    always_comb begin
        data_out = data_in[sel];
    end

endmodule : mux32

// File: rtl/register_file.sv
// 32 x N register file: one write port, two independent read ports, x0 reads zero.
module register_file
    import rf_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  reg_addr_t    wr_addr,
    input  logic [N-1:0] wr_data,
    input  reg_addr_t    rd_addr0,
    output logic [N-1:0] rd_data0,
    input  reg_addr_t    rd_addr1,
    output logic [N-1:0] rd_data1
);

    logic [REG_COUNT-1:0]        wr_en_onehot;
    logic [REG_COUNT-1:0][N-1:0] regs;

    // x0 has no storage, so its decode bit is intentionally left unconnected.
    logic unused_x0_wr;
    assign unused_x0_wr = wr_en_onehot[ZERO_REG];

    decoder5to32 u_wr_dec (
        .ena    (wr_ena),
        .addr   (wr_addr),
        .onehot (wr_en_onehot)
    );

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
        if (g == int'(ZERO_REG)) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_store
            logic [N-1:0] x_d;
            logic [N-1:0] x_q;

            // Load wr_data only when this register's decode bit is set.
            always_comb begin
                x_d = x_q;
                if (wr_en_onehot[g]) begin
                    x_d = wr_data;
                end
            end

            // Synchronous reset wins over a same-edge write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    x_q <= '0;
                end else begin
                    x_q <= x_d;
                end
            end

            assign regs[g] = x_q;
        end
    end

    mux32 #(.N(N)) u_rd_mux0 (
        .data_in  (regs),
        .sel      (rd_addr0),
        .data_out (rd_data0)
    );

    mux32 #(.N(N)) u_rd_mux1 (
        .data_in  (regs),
        .sel      (rd_addr1),
        .data_out (rd_data1)
    );

endmodule : register_file
